// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants, response-pipe entry type and clog2 helper for the SRAM arbiter
package sram_arb_pkg;

  localparam int DEF_RD_LATENCY = 2;
  // Wide enough to name any of up to 8 requesters.
  localparam int ID_WIDTH = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
  } rsp_entry_t;

  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - combinational masked round-robin picker: request vector and pointer to one-hot grant
module sram_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] upper_first;
  logic [NUM_REQ-1:0] any_first;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
  end

  assign upper_first = upper & (-upper);
  assign any_first   = req & (-req);
  assign gnt         = (|upper) ? upper_first : any_first;

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - round-robin arbiter sharing one SRAM port among NUM_REQ requesters
// Define SRAM_ARB_WR_PRIO_EN to let any pending write beat every pending read.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int RAM_DEPTH  = 16,
  parameter  int RAM_WIDTH  = 32,
  parameter  int RD_LATENCY = DEF_RD_LATENCY,
  localparam int ADDR_WIDTH = clog2_min1(RAM_DEPTH)
) (
  input  logic                          clockCore,
  input  logic                          resetCore,
  input  logic [NUM_REQ-1:0]            reqVld,
  input  logic [NUM_REQ-1:0]            reqWr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]  reqWrData,
  output logic [NUM_REQ-1:0]            reqGnt,
  output logic [NUM_REQ-1:0]            rspVld,
  output logic [RAM_WIDTH-1:0]          rspData,
  output logic                          sramRdEn,
  output logic                          sramWrEn,
  output logic [ADDR_WIDTH-1:0]         sramAddr,
  output logic [RAM_WIDTH-1:0]          sramWrData,
  input  logic [RAM_WIDTH-1:0]          sramRdData,
  output logic                          idle
);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [RAM_WIDTH-1:0]  win_data;
  logic                  accept;
  logic                  pipe_busy;
  rsp_entry_t            rsp_pipe [RD_LATENCY+1];

`ifdef SRAM_ARB_WR_PRIO_EN
  logic [NUM_REQ-1:0] wr_set;
  logic [NUM_REQ-1:0] wr_gnt;
  logic [NUM_REQ-1:0] all_gnt;

  assign wr_set = reqVld & reqWr;
  sram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_wr  (.req(wr_set), .ptr(rr_ptr), .gnt(wr_gnt));
  sram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_all (.req(reqVld), .ptr(rr_ptr), .gnt(all_gnt));
  assign reqGnt = (|wr_set) ? wr_gnt : all_gnt;
`else
  sram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_all (.req(reqVld), .ptr(rr_ptr), .gnt(reqGnt));
`endif

  assign accept = |reqGnt;

  always_comb begin
    win_id   = '0;
    next_ptr = '0;
    win_wr   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqGnt[i]) begin
        win_id   = ID_WIDTH'(i);
        next_ptr = (i == NUM_REQ - 1) ? '0 : ID_WIDTH'(i + 1);
        win_wr   = reqWr[i];
        win_addr = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = reqWrData[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      rr_ptr     <= '0;
      sramRdEn   <= 1'b0;
      sramWrEn   <= 1'b0;
      sramAddr   <= '0;
      sramWrData <= '0;
    end else begin
      sramRdEn <= accept && !win_wr;
      sramWrEn <= accept && win_wr;
      if (accept) begin
        rr_ptr     <= next_ptr;
        sramAddr   <= win_addr;
        sramWrData <= win_data;
      end
    end
  end

  // Stage s holds a read accepted s+1 cycles earlier; the last stage lines up with sramRdData.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      for (int s = 0; s <= RD_LATENCY; s++) rsp_pipe[s] <= '0;
    end else begin
      rsp_pipe[0] <= rsp_entry_t'{valid: accept && !win_wr, id: win_id};
      for (int s = 1; s <= RD_LATENCY; s++) rsp_pipe[s] <= rsp_pipe[s-1];
    end
  end

  always_comb begin
    rspVld    = '0;
    pipe_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_pipe[RD_LATENCY].valid && rsp_pipe[RD_LATENCY].id == ID_WIDTH'(i)) rspVld[i] = 1'b1;
    end
    for (int s = 0; s <= RD_LATENCY; s++) begin
      pipe_busy = pipe_busy | rsp_pipe[s].valid;
    end
  end

  assign rspData = sramRdData;
  assign idle    = !(|reqVld) && !pipe_busy;

endmodule
